// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Constants shared by the AES datapath stages.
//   - IDLE / SUB / DONE : state encoding for the serial byte-substitution FSMs
//   - AES_BLOCK_W       : width of one AES state in bits
//   - AES_BYTES         : number of bytes in one AES state
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

endpackage

// File: rtl/inv_sbox_lut.sv
// ----------------------------------------------------------------------------
// inv_sbox_lut
//   Purely combinational AES inverse S-box (FIPS-197 InvSbox).
//   Total over 00..ff, e.g. InvSbox(00)=52, (63)=00, (7c)=01, (16)=ff, (ff)=7d.
// Ports
//   a  in  8  byte to substitute
//   y  out 8  InvSbox(a)
// ----------------------------------------------------------------------------
module inv_sbox_lut (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[a];

endmodule

// File: rtl/inv_sbox_serial.sv
// ----------------------------------------------------------------------------
// inv_sbox_serial
//   AES InvSubBytes on a 128-bit state, BYTES_PER_CYCLE inverse S-box lookups
//   per clock. One block in flight; valid/ready on both sides.
// Parameters
//   BYTES_PER_CYCLE  lookups per SUB cycle (1, 2, 4, 8 or 16)
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    s_in carries a block
//   in_ready   out  1    block accepted when in_valid & in_ready
//   s_in       in   128  input state, byte i = s_in[8i+7:8i]
//   out_valid  out  1    s_o holds a finished block
//   out_ready  in   1    consumer takes s_o when out_valid & out_ready
//   s_o        out  128  InvSubBytes(s_in), same byte order
// ----------------------------------------------------------------------------
module inv_sbox_serial
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] s_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] s_o
);

    localparam int NCYC  = AES_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = $clog2(NCYC) + 1;
    localparam int SUB_W = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCYC - 1);

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [AES_BLOCK_W-1:0] work;
    logic [AES_BLOCK_W-1:0] acc;
    logic [AES_BLOCK_W-1:0] acc_nxt;
    logic [SUB_W-1:0]       sub;
    logic                   accept;

    // Lookups always operate on the low bytes of work; work is shifted down
    // each SUB cycle so every byte passes through these lanes exactly once.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
        inv_sbox_lut u_lut (
            .a (work[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    // Results enter at the top of acc and move down, so after NCYC shifts the
    // byte taken from lane position i ends up at byte i again. Written as a
    // shift of the concatenation so BYTES_PER_CYCLE=16 needs no special case.
    assign acc_nxt = AES_BLOCK_W'({sub, acc} >> SUB_W);

    // Ready is suppressed during reset so nothing is accepted on that edge.
    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            acc       <= '0;
            s_o       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= s_in;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    work <= work >> SUB_W;
                    acc  <= acc_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        s_o       <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work  <= s_in;
                            cnt   <= '0;
                            state <= SUB;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sbox_serial.sv
// ----------------------------------------------------------------------------
// tb_inv_sbox_serial
//   Bench for inv_sbox_serial: one instance with BYTES_PER_CYCLE=1 (index 0)
//   and one with BYTES_PER_CYCLE=4 (index 1), sharing clk and rst.
// ----------------------------------------------------------------------------
module tb_inv_sbox_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [127:0] si   [2];
    logic [127:0] so   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inv_sbox_serial #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .s_in(si[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .s_o(so[0])
    );

    inv_sbox_serial #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .s_in(si[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .s_o(so[1])
    );

    // Forward AES S-box, used to build round-trip stimulus.
    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [127:0] fwd_block(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = FWD[x[8*b +: 8]];
        return r;
    endfunction

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        name;
    } vec_t;

    vec_t vt [6];

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One block through instance k: wait for ready, present for one cycle,
    // count edges to out_valid, check result, then consume it.
    task automatic xfer(input int k, input logic [127:0] din, input logic [127:0] exp,
                        input string nm, input int lat);
        int e;
        bit irb;
        e = 0;
        irb = 0;
        while (!ir[k] && e < 50) begin
            @(posedge clk); #1; e++;
        end
        iv[k] = 1'b1;
        si[k] = din;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        si[k] = ~din;
        e = 0;
        while (!ov[k] && e < 100) begin
            if (ir[k]) irb = 1'b1;
            @(posedge clk); #1; e++;
        end
        chk_int({nm, " latency"}, e, lat);
        chk128({nm, " s_o"}, so[k], exp);
        chk_int({nm, " in_ready low while busy"}, int'(irb), 0);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk_int({nm, " out_valid cleared"}, int'(ov[k]), 0);
    endtask

    initial begin
        logic [127:0] q[$];
        logic [127:0] cur;
        logic [127:0] a63, a16, aff, a00;
        bit have;
        int done, cyc, e;

        a63 = {16{8'h63}};
        a16 = {16{8'h16}};
        aff = {16{8'hff}};
        a00 = '0;

        vt[0] = '{a63, a00, "all63"};
        vt[1] = '{128'hd42711aee0bf98f1b8b45de51e415230,
                  128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips"};
        vt[2] = '{a16, aff, "all16"};
        vt[3] = '{a00, {16{8'h52}}, "all00"};
        vt[4] = '{aff, {16{8'h7d}}, "allff"};
        vt[5] = '{128'h0f0e0d0c0b0a09080706050403020100,
                  128'hfbd7f3819ea340bf38a53630d56a0952, "ramp"};

        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; si[k] = '0;
        end

        // reset state
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_int("in_ready during reset", int'(ir[0]), 0);
        chk_int("out_valid after reset", int'(ov[0]), 0);
        chk128("s_o after reset", so[0], '0);
        rst = 1'b0;
        #1;
        chk_int("in_ready after reset", int'(ir[0]), 1);

        // directed vectors on both widths
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 6; i++)
                xfer(k, vt[i].din, vt[i].dout,
                     $sformatf("bpc%0d %s", (k == 0) ? 1 : 4, vt[i].name),
                     (k == 0) ? 16 : 4);

        // backpressure, then back-to-back accept while consuming
        iv[0] = 1'b1; si[0] = a63;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        e = 0;
        while (!ov[0] && e < 100) begin @(posedge clk); #1; e++; end
        chk_int("bp first latency", e, 16);
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'b1; si[0] = a16;
            #1;
            chk_int("bp in_ready held low", int'(ir[0]), 0);
            @(posedge clk); #1;
            chk_int("bp out_valid held", int'(ov[0]), 1);
            chk128("bp s_o held", so[0], a00);
        end
        ordy[0] = 1'b1;
        #1;
        chk_int("b2b in_ready with out_ready", int'(ir[0]), 1);
        @(posedge clk); #1;
        ordy[0] = 1'b0; iv[0] = 1'b0; si[0] = '0;
        chk_int("b2b first consumed", int'(ov[0]), 0);
        e = 0;
        while (!ov[0] && e < 100) begin @(posedge clk); #1; e++; end
        chk_int("b2b second latency", e, 16);
        chk128("b2b second s_o", so[0], aff);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;

        // reset in the middle of a block
        iv[0] = 1'b1; si[0] = vt[1].din;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_int("midrst out_valid", int'(ov[0]), 0);
        chk128("midrst s_o", so[0], '0);
        chk_int("midrst in_ready", int'(ir[0]), 1);
        e = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov[0]) e++;
        end
        chk_int("midrst no output for dropped block", e, 0);
        xfer(0, vt[5].din, vt[5].dout, "midrst fresh block", 16);

        // round trip with random handshake toggling
        done = 0; cyc = 0; have = 1'b0;
        while (done < 1000 && cyc < 80000) begin
            if (!have) begin
                cur = {$urandom, $urandom, $urandom, $urandom};
                have = 1'b1;
            end
            iv[0]   = ($urandom_range(0, 3) != 0);
            si[0]   = fwd_block(cur);
            ordy[0] = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (ov[0] && ordy[0]) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL roundtrip: output with no block outstanding, got %h", so[0]);
                end else begin
                    chk128("roundtrip", so[0], q.pop_front());
                end
                done++;
            end
            if (iv[0] && ir[0]) begin
                q.push_back(cur);
                have = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk_int("roundtrip blocks completed", done, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
